// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div, serves mfhi/mflo.
// Define MDU_MADD_EN to accept the madd/maddu/msub/msubu accumulate ops.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDUop,
   input  logic [31:0] E_RS,
   input  logic [31:0] E_RT,
   output logic        E_MDUbusy,
   output logic [31:0] E_MDUres,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   // state   | meaning
   // ST_IDLE | no operation in flight; new ops, mthi/mtlo accepted
   // ST_BUSY | mult/div counting down; the result commits at terminal count 1

   localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3, OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5, OP_MFLO  = 4'd6, OP_MTHI  = 4'd7, OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11, OP_MSUBU = 4'd12;
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] res_q, res_d;
   logic        wr_q, wr_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] div_b, mag_a, mag_b, q_mag, r_mag, quot_s, rem_s;
   logic        launch, launch_wr;
   logic [63:0] launch_res;
   logic [3:0]  launch_cnt;

   // Sign-extended operands give the signed product modulo 2^64.
   assign prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
   assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};

   // Signed divide done on magnitudes so 0x80000000 / -1 simply wraps.
   assign div_b  = (E_RT == 32'd0) ? 32'd1 : E_RT;
   assign mag_a  = E_RS[31] ? (32'd0 - E_RS) : E_RS;
   assign mag_b  = div_b[31] ? (32'd0 - div_b) : div_b;
   assign q_mag  = mag_a / mag_b;
   assign r_mag  = mag_a % mag_b;
   assign quot_s = (E_RS[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
   assign rem_s  = E_RS[31] ? (32'd0 - r_mag) : r_mag;

   always_comb begin
      launch     = 1'b0;
      launch_wr  = 1'b1;
      launch_res = 64'd0;
      launch_cnt = MULT_LOAD;
      unique case (E_MDUop)
         OP_MULT:  begin launch = 1'b1; launch_res = prod_s; end
         OP_MULTU: begin launch = 1'b1; launch_res = prod_u; end
         OP_DIV: begin
            launch     = 1'b1;
            launch_cnt = DIV_LOAD;
            launch_wr  = (E_RT != 32'd0);
            launch_res = {rem_s, quot_s};
         end
         OP_DIVU: begin
            launch     = 1'b1;
            launch_cnt = DIV_LOAD;
            launch_wr  = (E_RT != 32'd0);
            launch_res = {E_RS % div_b, E_RS / div_b};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin launch = 1'b1; launch_res = {hi_q, lo_q} + prod_s; end
         OP_MADDU: begin launch = 1'b1; launch_res = {hi_q, lo_q} + prod_u; end
         OP_MSUB:  begin launch = 1'b1; launch_res = {hi_q, lo_q} - prod_s; end
         OP_MSUBU: begin launch = 1'b1; launch_res = {hi_q, lo_q} - prod_u; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      wr_d    = wr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_BUSY;
               cnt_d   = launch_cnt;
               res_d   = launch_res;
               wr_d    = launch_wr;
            end else if (E_MDUop == OP_MTHI) begin
               hi_d = E_RS;
            end else if (E_MDUop == OP_MTLO) begin
               lo_d = E_RS;
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               if (wr_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         res_q   <= 64'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
      end
   end

   assign E_MDUbusy = (state_q == ST_BUSY);
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign E_MDUres  = (E_MDUop == OP_MFHI) ? hi_q :
                      (E_MDUop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: reset, mult/div latency and results, divide by zero,
// mthi/mtlo, ignored ops while busy, reset mid-operation, madd-family gating.
module tb_e_mdu;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDUop;
   logic [31:0] E_RS, E_RT;
   logic        E_MDUbusy;
   logic [31:0] E_MDUres, HI, LO;

   int checks = 0;
   int errors = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .E_MDUop(E_MDUop), .E_RS(E_RS), .E_RT(E_RT),
      .E_MDUbusy(E_MDUbusy), .E_MDUres(E_MDUres), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; E_MDUop = 4'd0; E_RS = 32'd0; E_RT = 32'd0;
      tick(); tick();
      reset = 1'b1;
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", {31'd0, E_MDUbusy}, 32'd0);
      chk("rst_res", E_MDUres, 32'd0);

      // mult -3 * 5
      E_MDUop = 4'd1; E_RS = 32'hFFFF_FFFD; E_RT = 32'd5;
      tick();
      E_MDUop = 4'd0;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("mult_busy_c%0d", i), {31'd0, E_MDUbusy}, 32'd1);
         tick();
      end
      chk("mult_lo_held_then", {31'd0, E_MDUbusy}, 32'd0);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFF1);
      E_MDUop = 4'd5; #1;
      chk("mfhi", E_MDUres, 32'hFFFF_FFFF);
      E_MDUop = 4'd6; #1;
      chk("mflo", E_MDUres, 32'hFFFF_FFF1);
      E_MDUop = 4'd0; #1;
      chk("res_noop", E_MDUres, 32'd0);

      // div -7 / 2 with illegal ops injected while busy
      E_MDUop = 4'd3; E_RS = 32'hFFFF_FFF9; E_RT = 32'd2;
      tick();
      for (int i = 1; i <= 10; i++) begin
         E_MDUop = 4'd0;
         chk($sformatf("div_busy_c%0d", i), {31'd0, E_MDUbusy}, 32'd1);
         if (i == 3) begin E_MDUop = 4'd8; E_RS = 32'hDEAD_BEEF; end
         if (i == 5) begin E_MDUop = 4'd1; E_RS = 32'd9; E_RT = 32'd9; end
         if (i == 7) begin E_MDUop = 4'd7; E_RS = 32'h0BAD_0BAD; end
         tick();
      end
      E_MDUop = 4'd0;
      chk("div_busy_end", {31'd0, E_MDUbusy}, 32'd0);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);

      // divu 7 / 2 launched back-to-back
      E_MDUop = 4'd4; E_RS = 32'd7; E_RT = 32'd2;
      tick();
      E_MDUop = 4'd0;
      for (int i = 1; i <= 10; i++) begin
         chk($sformatf("divu_busy_c%0d", i), {31'd0, E_MDUbusy}, 32'd1);
         tick();
      end
      chk("divu_busy_end", {31'd0, E_MDUbusy}, 32'd0);
      chk("divu_lo", LO, 32'd3);
      chk("divu_hi", HI, 32'd1);

      // mthi latency, then divide by zero
      E_MDUop = 4'd7; E_RS = 32'h1234_5678; #1;
      chk("mthi_before_edge", HI, 32'd1);
      tick();
      E_MDUop = 4'd0;
      chk("mthi_after_edge", HI, 32'h1234_5678);
      E_MDUop = 4'd4; E_RS = 32'd100; E_RT = 32'd0;
      tick();
      E_MDUop = 4'd0;
      for (int i = 1; i <= 10; i++) begin
         chk($sformatf("div0_busy_c%0d", i), {31'd0, E_MDUbusy}, 32'd1);
         tick();
      end
      chk("div0_busy_end", {31'd0, E_MDUbusy}, 32'd0);
      chk("div0_hi", HI, 32'h1234_5678);
      chk("div0_lo", LO, 32'd3);

      // multu max*max with reset in busy cycle 3
      E_MDUop = 4'd2; E_RS = 32'hFFFF_FFFF; E_RT = 32'hFFFF_FFFF;
      tick();
      E_MDUop = 4'd0;
      chk("multu_busy_c1", {31'd0, E_MDUbusy}, 32'd1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("midrst_busy", {31'd0, E_MDUbusy}, 32'd0);
      chk("midrst_hi", HI, 32'd0);
      chk("midrst_lo", LO, 32'd0);
      for (int i = 0; i < 8; i++) tick();
      chk("midrst_late_busy", {31'd0, E_MDUbusy}, 32'd0);
      chk("midrst_late_hi", HI, 32'd0);
      chk("midrst_late_lo", LO, 32'd0);

      // maddu 1*1 onto HI=0, LO=0xFFFFFFFF
      E_MDUop = 4'd8; E_RS = 32'hFFFF_FFFF;
      tick();
      E_MDUop = 4'd0;
      chk("mtlo", LO, 32'hFFFF_FFFF);
      E_MDUop = 4'd10; E_RS = 32'd1; E_RT = 32'd1;
      tick();
      E_MDUop = 4'd0;
`ifdef MDU_MADD_EN
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("maddu_busy_c%0d", i), {31'd0, E_MDUbusy}, 32'd1);
         tick();
      end
      chk("maddu_busy_end", {31'd0, E_MDUbusy}, 32'd0);
      chk("maddu_hi", HI, 32'd1);
      chk("maddu_lo", LO, 32'd0);
`else
      for (int i = 1; i <= 6; i++) begin
         chk($sformatf("maddu_nobusy_c%0d", i), {31'd0, E_MDUbusy}, 32'd0);
         tick();
      end
      chk("maddu_off_hi", HI, 32'd0);
      chk("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
